// File: rtl/izh_array.sv
// Time-multiplexed Izhikevich neuron array: one shared fixed-point datapath
// updates one neuron per clock, and the sweep's spike vector is published on done.
module izh_array #(
    parameter int N_NEURONS = 4,
    parameter int W         = 16,
    parameter int FRAC      = 7,
    parameter int CUR_W     = 8,
    parameter int DT_SHIFT  = 2,
    parameter int REFRAC    = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       step,
    input  logic [1:0]                 mode,
    input  logic [N_NEURONS*CUR_W-1:0] cur_in,
    output logic                       busy,
    output logic                       done,
    output logic [N_NEURONS-1:0]       spike,
    output logic [N_NEURONS*W-1:0]     v_out,
    output logic                       sat
);
    localparam int IW   = 2*W + 4;
    localparam int IDXW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int SC   = 2**FRAC;

    // a and b are rounded to nearest at elaboration so they track FRAC
    localparam logic signed [IW-1:0] A_SLOW = IW'((2*SC + 50) / 100);
    localparam logic signed [IW-1:0] A_FAST = IW'((10*SC + 50) / 100);
    localparam logic signed [IW-1:0] B_ALL  = IW'((20*SC + 50) / 100);
    localparam logic signed [IW-1:0] D_RS   = IW'(8*SC);
    localparam logic signed [IW-1:0] D_FSCH = IW'(2*SC);
    localparam logic signed [IW-1:0] D_IB   = IW'(4*SC);
    localparam logic signed [IW-1:0] TH     = IW'(30*SC);
    localparam logic signed [IW-1:0] K140   = IW'(140*SC);
    localparam logic signed [W-1:0]  C_RS   = W'(-65*SC);
    localparam logic signed [W-1:0]  C_CH   = W'(-50*SC);
    localparam logic signed [W-1:0]  C_IB   = W'(-55*SC);
    localparam logic signed [W-1:0]  U_RST  = W'(-13*SC);
    localparam logic signed [IW-1:0] SAT_MAX = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPDATE = 2'd1, S_DONE = 2'd2} state_t;

    // Clamp to the signed W range; MSB of the result flags that clamping happened.
    function automatic logic [W:0] sat_fn(input logic signed [IW-1:0] x);
        logic [W:0] r;
        if (x > SAT_MAX)      r = {1'b1, 1'b0, {(W-1){1'b1}}};
        else if (x < SAT_MIN) r = {1'b1, 1'b1, {(W-1){1'b0}}};
        else                  r = {1'b0, x[W-1:0]};
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [1:0]            mode_q, mode_d;
    logic signed [W-1:0]   v_q [N_NEURONS];
    logic signed [W-1:0]   v_d [N_NEURONS];
    logic signed [W-1:0]   u_q [N_NEURONS];
    logic signed [W-1:0]   u_d [N_NEURONS];
    logic [RW-1:0]         ref_q [N_NEURONS];
    logic [RW-1:0]         ref_d [N_NEURONS];
    logic [N_NEURONS-1:0]  shadow_q, shadow_d, spike_q, spike_d;
    logic                  busy_q, busy_d, done_q, done_d, sat_q, sat_d;

    logic signed [IW-1:0]  a_s, d_s, v_x, u_x, i_x, dv_s, du_s;
    logic signed [W-1:0]   c_s;
    logic [W:0]            v_new_s, u_new_s, u_spk_s;
    logic                  fire_s;

    // Shared datapath for the neuron selected by idx.
    always_comb begin
        a_s = A_SLOW;
        c_s = C_RS;
        d_s = D_RS;
        case (mode_q)
            2'd0:    begin a_s = A_SLOW; c_s = C_RS; d_s = D_RS;   end
            2'd1:    begin a_s = A_FAST; c_s = C_RS; d_s = D_FSCH; end
            2'd2:    begin a_s = A_SLOW; c_s = C_CH; d_s = D_FSCH; end
            2'd3:    begin a_s = A_SLOW; c_s = C_IB; d_s = D_IB;   end
            default: begin a_s = A_SLOW; c_s = C_RS; d_s = D_RS;   end
        endcase
        v_x  = {{(IW-W){v_q[idx_q][W-1]}}, v_q[idx_q]};
        u_x  = {{(IW-W){u_q[idx_q][W-1]}}, u_q[idx_q]};
        i_x  = {{(IW-CUR_W){1'b0}}, cur_in[idx_q*CUR_W +: CUR_W]} <<< FRAC;
        dv_s = ((v_x * v_x) >>> (FRAC + 5)) + (v_x <<< 2) + v_x + K140 - u_x + i_x;
        du_s = (a_s * (((B_ALL * v_x) >>> FRAC) - u_x)) >>> FRAC;
        v_new_s = sat_fn(v_x + (dv_s >>> DT_SHIFT));
        u_new_s = sat_fn(u_x + (du_s >>> DT_SHIFT));
        u_spk_s = sat_fn(u_x + d_s);
        fire_s  = (v_x >= TH);
    end

    // Sweep sequencing and per-neuron state update (spike, refractory, integrate).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        v_d      = v_q;
        u_d      = u_q;
        ref_d    = ref_q;
        shadow_d = shadow_q;
        spike_d  = spike_q;
        done_d   = 1'b0;
        sat_d    = sat_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (step) begin
                    state_d  = S_UPDATE;
                    idx_d    = '0;
                    mode_d   = mode;
                    shadow_d = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_UPDATE: begin
                if (fire_s) begin
                    v_d[idx_q]      = c_s;
                    u_d[idx_q]      = u_spk_s[W-1:0];
                    ref_d[idx_q]    = RW'(REFRAC);
                    shadow_d[idx_q] = 1'b1;
                    sat_d           = sat_q | u_spk_s[W];
                end else if (ref_q[idx_q] != '0) begin
                    // Clamped to reset potential: current is ignored, recovery keeps evolving
                    v_d[idx_q]   = c_s;
                    u_d[idx_q]   = u_new_s[W-1:0];
                    ref_d[idx_q] = ref_q[idx_q] - RW'(1);
                    sat_d        = sat_q | u_new_s[W];
                end else begin
                    v_d[idx_q] = v_new_s[W-1:0];
                    u_d[idx_q] = u_new_s[W-1:0];
                    sat_d      = sat_q | v_new_s[W] | u_new_s[W];
                end
                if (idx_q == IDXW'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                    spike_d = shadow_d;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mode_q   <= 2'd0;
            shadow_q <= '0;
            spike_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_q[k]   <= C_RS;
                u_q[k]   <= U_RST;
                ref_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            spike_q  <= spike_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            v_q      <= v_d;
            u_q      <= u_d;
            ref_q    <= ref_d;
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_vout
        assign v_out[g*W +: W] = v_q[g];
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign spike = spike_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_izh_array.sv
// Self-checking bench for izh_array: a 4-neuron default instance and a 1-neuron,
// 15-bit, non-refractory instance, both compared sweep by sweep against a reference model.
module tb_izh_array;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_a, step_b;
    logic [1:0]  mode_a, mode_b;
    logic [31:0] cur_a;
    logic [7:0]  cur_b;
    logic        busy_a, done_a, sat_a, busy_b, done_b, sat_b;
    logic [3:0]  spike_a;
    logic [0:0]  spike_b;
    logic [63:0] vout_a;
    logic [14:0] vout_b;

    int checks = 0;
    int errors = 0;

    longint mv[4], mu[4];
    int     mr[4];
    bit [3:0] m_spk;
    bit       m_sat;
    longint bv, bu;
    int     br;
    bit     b_spk, b_sat;

    always #5 clk = ~clk;

    izh_array dut_a (
        .clk(clk), .reset_n(reset_n), .step(step_a), .mode(mode_a), .cur_in(cur_a),
        .busy(busy_a), .done(done_a), .spike(spike_a), .v_out(vout_a), .sat(sat_a)
    );

    izh_array #(.N_NEURONS(1), .W(15), .REFRAC(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .step(step_b), .mode(mode_b), .cur_in(cur_b),
        .busy(busy_b), .done(done_b), .spike(spike_b), .v_out(vout_b), .sat(sat_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint va(input int k);
        return longint'($signed(vout_a[k*16 +: 16]));
    endfunction

    task automatic clampw(input longint x, input int w, output longint y, output bit s);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        s  = (x > mx) || (x < -mx - 1);
        y  = (x > mx) ? mx : ((x < -mx - 1) ? -mx - 1 : x);
    endtask

    // One Izhikevich step in mV*128 units, straight from the neuron rules.
    task automatic neuron_step(input int m, input longint cur, input int w, input int refrac,
                               inout longint v, inout longint u, inout int r,
                               output bit sp, output bit sh);
        longint a, c, d, du, dv, un, vn;
        bit s1, s2;
        a  = (m == 1) ? 13 : 3;
        c  = (m == 2) ? -50*128 : ((m == 3) ? -55*128 : -65*128);
        d  = (m == 0) ? 8*128 : ((m == 3) ? 4*128 : 2*128);
        sp = 1'b0;
        sh = 1'b0;
        if (v >= 30*128) begin
            sp = 1'b1;
            clampw(u + d, w, un, sh);
            u = un;
            v = c;
            r = refrac;
        end else begin
            du = (a * (((26*v) >>> 7) - u)) >>> 7;
            clampw(u + (du >>> 2), w, un, s1);
            if (r > 0) begin
                v  = c;
                r  = r - 1;
                sh = s1;
            end else begin
                dv = ((v*v) >>> 12) + 5*v + 140*128 - u + cur*128;
                clampw(v + (dv >>> 2), w, vn, s2);
                v  = vn;
                sh = s1 | s2;
            end
            u = un;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mv[k] = -8320; mu[k] = -1664; mr[k] = 0;
        end
        m_spk = '0; m_sat = 1'b0;
        bv = -8320; bu = -1664; br = 0; b_spk = 1'b0; b_sat = 1'b0;
    endtask

    task automatic model_sweep_a(input int m, input bit [31:0] cur, output bit [3:0] nsp);
        bit sp, sh;
        for (int k = 0; k < 4; k++) begin
            neuron_step(m, longint'(cur[k*8 +: 8]), 16, 2, mv[k], mu[k], mr[k], sp, sh);
            nsp[k] = sp;
            m_sat  = m_sat | sh;
        end
    endtask

    // Sweep on instance A: per-edge v_out checks, stray step pulses, late current changes.
    task automatic sweep_a(input int m, input bit [31:0] cur);
        longint oldv[4];
        bit [3:0] nsp;
        oldv = mv;
        model_sweep_a(m, cur, nsp);
        mode_a = 2'(m); cur_a = cur; step_a = 1'b1;
        tick();
        step_a = 1'b0;
        mode_a = 2'($urandom_range(0, 3));
        chk("a_busy_start", busy_a, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("a_v%0d", k), va(k), mv[k]);
            if (k < 3) begin
                chk($sformatf("a_v%0d_hold", k + 1), va(k + 1), oldv[k + 1]);
                chk("a_spike_hold", spike_a, m_spk);
                chk("a_done_early", done_a, 0);
                cur_a[k*8 +: 8] = 8'($urandom);
                step_a = 1'($urandom_range(0, 1));
            end
        end
        step_a = 1'b0;
        m_spk  = nsp;
        chk("a_spike", spike_a, m_spk);
        chk("a_done", done_a, 1);
        chk("a_busy_done", busy_a, 1);
        chk("a_sat", sat_a, m_sat);
        tick();
        chk("a_done_clear", done_a, 0);
        chk("a_busy_clear", busy_a, 0);
    endtask

    task automatic sweep_b(input int m, input bit [7:0] cur);
        bit sh;
        neuron_step(m, longint'(cur), 15, 0, bv, bu, br, b_spk, sh);
        b_sat = b_sat | sh;
        mode_b = 2'(m); cur_b = cur; step_b = 1'b1;
        tick();
        step_b = 1'b0;
        chk("b_busy_start", busy_b, 1);
        tick();
        chk("b_v", longint'($signed(vout_b)), bv);
        chk("b_spike", spike_b, b_spk);
        chk("b_done", done_b, 1);
        chk("b_sat", sat_b, b_sat);
        tick();
        chk("b_done_clear", done_b, 0);
        chk("b_busy_clear", busy_b, 0);
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 4; k++) chk($sformatf("rst_v%0d", k), va(k), -8320);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_spike", spike_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_b_v", longint'($signed(vout_b)), -8320);
        chk("rst_b_busy", busy_b, 0);
    endtask

    initial begin
        bit [3:0] nsp;
        int spikes_seen;
        reset_n = 1'b0; step_a = 1'b0; step_b = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0; cur_a = '0; cur_b = '0;
        model_reset();
        tick(); tick();
        reset_n = 1'b1;
        check_reset_state();

        // Rest: no input, resting dynamics only
        for (int s = 0; s < 200; s++) sweep_a(0, 32'h0);

        // Drive isolation on neuron 0
        for (int s = 0; s < 60; s++) sweep_a(0, 32'h0000_000A);

        // Chattering with refractory hold, then fast vs regular spiking
        for (int s = 0; s < 40; s++) sweep_a(2, 32'h0F0F_0F0F);
        for (int s = 0; s < 40; s++) sweep_a(1, 32'h6464_6464);
        for (int s = 0; s < 40; s++) sweep_a(0, 32'h6464_6464);

        // Randomised modes, currents and idle gaps
        spikes_seen = 0;
        for (int s = 0; s < 150; s++) begin
            sweep_a($urandom_range(0, 3), $urandom);
            spikes_seen += $countones(m_spk);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
                chk("a_idle_busy", busy_a, 0);
            end
        end

        // Full drive on every neuron
        for (int s = 0; s < 40; s++) sweep_a($urandom_range(0, 3), 32'hFFFF_FFFF);

        // Step held high: back-to-back sweeps every N+1 cycles
        cur_a = 32'h80C0_40FF; mode_a = 2'd1; step_a = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("hs_done_low", done_a, 0);
            chk("hs_busy", busy_a, 1);
            model_sweep_a(1, 32'h80C0_40FF, nsp);
            for (int k = 0; k < 4; k++) begin
                tick();
                if (k < 3) chk("hs_done_gap", done_a, 0);
            end
            m_spk = nsp;
            chk("hs_done", done_a, 1);
            chk("hs_spike", spike_a, m_spk);
            for (int k = 0; k < 4; k++) chk($sformatf("hs_v%0d", k), va(k), mv[k]);
        end
        step_a = 1'b0;
        tick();
        chk("hs_idle_busy", busy_a, 0);
        chk("hs_idle_done", done_a, 0);

        // Single-neuron 15-bit instance: heavy drive exercises clamping
        for (int s = 0; s < 60; s++) sweep_b($urandom_range(0, 3), 8'hFF);
        for (int s = 0; s < 120; s++) sweep_b($urandom_range(0, 3), 8'($urandom));

        // Reset in the middle of a sweep aborts it without a done pulse
        mode_a = 2'd0; cur_a = 32'hFFFF_FFFF; step_a = 1'b1;
        tick();
        step_a = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        model_reset();
        check_reset_state();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_no_done", done_a, 0);
        end
        sweep_a(3, 32'h1020_3040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
